// File: rtl/rnd_lfsr_bank_if.sv
// Sample stream and seed-load bus of the LFSR noise bank.
// master = generator side, slave = controller/consumer side.
interface rnd_lfsr_bank_if #(
    parameter int CHANNELS = 8,
    parameter int LFSR_W   = 32
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                en;
    logic                seed_load;
    logic [SEL_W-1:0]    seed_sel;
    logic [LFSR_W-1:0]   seed_data;
    logic [CHANNELS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                lock_err;

    modport master (
        input  en, seed_load, seed_sel, seed_data, out_ready,
        output out_data, out_valid, lock_err
    );

    modport slave (
        output en, seed_load, seed_sel, seed_data, out_ready,
        input  out_data, out_valid, lock_err
    );
endinterface

// File: rtl/rnd_lfsr_bank.sv
// Bank of independent Fibonacci LFSRs emitting one noise bit per channel per
// transferred sample, with backpressure, runtime seed load and zero-lock repair.
module rnd_lfsr_bank #(
    parameter int          CHANNELS  = 8,
    parameter int          LFSR_W    = 32,
    parameter int          TAP_A     = 30,
    parameter int          TAP_B     = 27,
    parameter int          OUT_BIT   = 5,
    parameter logic [31:0] SEED_BASE = 32'h1A92_6572,
    parameter logic [31:0] SEED_STEP = 32'h2AA9_54B3
) (
    input logic             clk,
    input logic             rst_n,
    rnd_lfsr_bank_if.master bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SEL_W:0] NUM_CH = (SEL_W + 1)'(CHANNELS);

    typedef logic [LFSR_W-1:0] word_t;

    // All-zero feedback window would freeze the register forever.
    function automatic logic is_locked(input word_t v);
        return v[TAP_A:0] == '0;
    endfunction

    function automatic word_t fix(input word_t v);
        return is_locked(v) ? word_t'(1) : v;
    endfunction

    function automatic word_t step(input word_t s);
        return (s << 1) | word_t'(s[TAP_A] ^ s[TAP_B]);
    endfunction

    function automatic word_t reset_seed(input int c);
        return fix(word_t'(SEED_BASE) ^ (word_t'(c) * word_t'(SEED_STEP)));
    endfunction

    word_t               state [CHANNELS];
    logic [CHANNELS-1:0] sample;
    logic [CHANNELS-1:0] out_data_q;
    logic                out_valid_q;
    logic                lock_err_q;
    logic                adv;
    logic                load_hit;

    assign adv      = bus.en && (!out_valid_q || bus.out_ready);
    assign load_hit = bus.seed_load && ({1'b0, bus.seed_sel} < NUM_CH);

    always_comb begin
        sample = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sample[CHANNELS-1-c] = state[c][OUT_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state[c] <= reset_seed(c);
            end
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            lock_err_q  <= 1'b0;
        end else begin
            if (adv) begin
                out_data_q  <= sample;
                out_valid_q <= 1'b1;
            end else if (!bus.en && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // A seed load wins over the step, but only for the addressed channel.
            for (int c = 0; c < CHANNELS; c++) begin
                if (load_hit && (int'(bus.seed_sel) == c)) begin
                    state[c] <= fix(bus.seed_data);
                end else if (adv) begin
                    state[c] <= step(state[c]);
                end
            end

            if (load_hit && is_locked(bus.seed_data)) begin
                lock_err_q <= 1'b1;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.lock_err  = lock_err_q;
endmodule

// File: tb/tb_rnd_lfsr_bank.sv
// Randomised scoreboard bench for rnd_lfsr_bank: an 8-channel and a 3-channel
// instance checked against a sequence-level reference model.
module tb_rnd_lfsr_bank;
    localparam int TA = 30;
    localparam int TB = 27;
    localparam int OB = 5;
    localparam logic [31:0] SB = 32'h1A92_6572;
    localparam logic [31:0] SS = 32'h2AA9_54B3;

    logic clk;
    logic rst_n;

    rnd_lfsr_bank_if #(.CHANNELS(8), .LFSR_W(32)) bus ();
    rnd_lfsr_bank_if #(.CHANNELS(3), .LFSR_W(32)) bus3 ();

    rnd_lfsr_bank #(.CHANNELS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    rnd_lfsr_bank #(.CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] ms [8];
    logic [31:0] s3 [3];
    bit          mvalid;
    bit          mlock;
    logic [7:0]  exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic form of the shift-register recurrence.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        return (s * 32'd2) + (((s >> TA) ^ (s >> TB)) & 32'd1);
    endfunction

    function automatic logic [31:0] m_fix(input logic [31:0] v);
        return ((v % (32'h1 << (TA + 1))) == 32'd0) ? 32'd1 : v;
    endfunction

    function automatic logic [31:0] m_seed(input int c);
        return m_fix(SB ^ (32'(c) * SS));
    endfunction

    function automatic logic [7:0] word8();
        logic [7:0] w = '0;
        for (int c = 0; c < 8; c++) w[7-c] = ms[c][OB];
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 8; c++) ms[c] = m_seed(c);
        mvalid = 0;
        mlock  = 0;
        exp_q.delete();
    endtask

    // Called #1 after a rising edge; drives one cycle and advances the model.
    task automatic cycle(input bit e, input bit r, input bit ld,
                         input logic [2:0] sel, input logic [31:0] d);
        bit adv;
        bus.en = e; bus.out_ready = r; bus.seed_load = ld;
        bus.seed_sel = sel; bus.seed_data = d;
        adv = e && (!mvalid || r);
        if (adv) begin
            exp_q.push_back(word8());
            mvalid = 1;
            for (int c = 0; c < 8; c++) ms[c] = m_step(ms[c]);
        end else if (!e && r) begin
            mvalid = 0;
        end
        if (ld) begin
            if (m_fix(d) != d) mlock = 1;
            ms[sel] = m_fix(d);
        end
        @(posedge clk); #1;
        bus.seed_load = 1'b0;
        chk("out_valid", 32'(bus.out_valid), 32'(mvalid));
        chk("lock_err", 32'(bus.lock_err), 32'(mlock));
    endtask

    // Monitor: every presented sample must equal the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("sample_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.en = 0; bus.out_ready = 0; bus.seed_load = 0; bus.seed_sel = '0; bus.seed_data = '0;
        bus3.en = 0; bus3.out_ready = 0; bus3.seed_load = 0; bus3.seed_sel = '0; bus3.seed_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_lock", 32'(bus.lock_err), 32'd0);
        rst_n = 1'b1;

        // Free run from reset seeds
        repeat (6) cycle(1, 1, 0, 3'd0, 32'd0);

        // Single-bit seed in ch0 walks through OUT_BIT exactly once in 30 transfers
        cycle(0, 1, 1, 3'd0, 32'd1);
        for (int k = 1; k <= 30; k++) begin
            cycle(1, 1, 0, 3'd0, 32'd0);
            chk($sformatf("walk_bit_t%0d", k), 32'(bus.out_data[7]), (k == 6) ? 32'd1 : 32'd0);
        end

        // Stall mid-stream, then resume
        repeat (10) cycle(1, 0, 0, 3'd0, 32'd0);
        repeat (10) cycle(1, 1, 0, 3'd0, 32'd0);

        // Zero-lock seeds into ch3
        cycle(1, 1, 1, 3'd3, 32'd0);
        repeat (5) cycle(1, 1, 0, 3'd0, 32'd0);
        cycle(1, 1, 1, 3'd3, 32'h8000_0000);
        repeat (5) cycle(1, 1, 0, 3'd0, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            cycle($urandom_range(3) != 0, $urandom_range(9) < 7,
                  $urandom_range(19) == 0, 3'($urandom_range(7)), d);
        end

        // Reset while a sample is pending
        repeat (3) cycle(1, 0, 0, 3'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_data", 32'(bus.out_data), 32'd0);
        chk("midrst_lock", 32'(bus.lock_err), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) cycle(1, 1, 0, 3'd0, 32'd0);

        // 3-channel instance: out-of-range seed select is ignored
        bus.en = 0; bus.out_ready = 0;
        for (int c = 0; c < 3; c++) s3[c] = m_seed(c);
        chk("c3_valid0", 32'(bus3.out_valid), 32'd0);
        bus3.seed_load = 1; bus3.seed_sel = 2'd3; bus3.seed_data = 32'd0; bus3.out_ready = 1;
        @(posedge clk); #1;
        bus3.seed_load = 0;
        chk("c3_lock", 32'(bus3.lock_err), 32'd0);
        bus3.en = 1;
        for (int k = 0; k < 6; k++) begin
            logic [2:0] w;
            w = {s3[0][OB], s3[1][OB], s3[2][OB]};
            for (int c = 0; c < 3; c++) s3[c] = m_step(s3[c]);
            @(posedge clk); #1;
            chk("c3_valid", 32'(bus3.out_valid), 32'd1);
            chk($sformatf("c3_data%0d", k), 32'(bus3.out_data), 32'(w));
        end
        chk("c3_lock_end", 32'(bus3.lock_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rnd_lfsr_bank.md
Name: rnd_lfsr_bank

Overview:
Parametrised bank of independent Fibonacci LFSRs. Each cycle that a sample is transferred, it emits one pseudo-random bit per channel, packed into an output word.
- Generalises the fixed 8-channel, 32-bit noise source: configurable channel count, register width, taps and output bit.
- Adds async reset, run enable, valid/ready backpressure, runtime per-channel seed load and zero-lock protection.
- Feeds noise/dither consumers in the synth datapath.

Parameters:
CHANNELS, 8, number of LFSR channels (1..32).
LFSR_W, 32, state register width per channel.
TAP_A, 30, first feedback bit index (< LFSR_W).
TAP_B, 27, second feedback bit index (< TAP_A).
OUT_BIT, 5, state bit index sampled per channel (< LFSR_W).
SEED_BASE, 32'h1A92_6572, reset seed base.
SEED_STEP, 32'h2AA9_54B3, per-channel seed offset.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  run enable; generator advances only while high.
seed_load  in  1  one-cycle strobe: load seed_data into channel seed_sel.
seed_sel  in  SEL_W=max(1,$clog2(CHANNELS))  target channel of seed load.
seed_data  in  LFSR_W  seed value.
out_data  out  CHANNELS  sample word; channel 0 at MSB, channel CHANNELS-1 at LSB.
out_valid  out  1  out_data holds an untransferred or current sample.
out_ready  in  1  consumer accepts sample when out_valid && out_ready.
lock_err  out  1  sticky flag: a zero-lock seed was loaded and corrected.

Behaviour:
- Reset (rst_n low, async assert, sync release):
  - state[c] = fix(SEED_BASE ^ (c*SEED_STEP)), truncated to LFSR_W.
  - out_data = 0, out_valid = 0, lock_err = 0.
- fix(v): if v[TAP_A:0] == 0, the result is 1; otherwise v.
- Step function: next = {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B]}.
- adv = en && (!out_valid || out_ready).
- On adv:
  - out_data <= {state[0][OUT_BIT], ..., state[CHANNELS-1][OUT_BIT]}, taken from pre-step state.
  - out_valid <= 1.
  - Every channel steps.
  - Latency: state sampled at edge k appears on out_data after edge k.
- Backpressure: out_valid && !out_ready means out_data is held and all states frozen. No sample is ever dropped or skipped.
- !en && out_ready && out_valid: out_valid <= 0, states frozen.
- !en && !out_ready: everything holds.
- Seed load (seed_load high, seed_sel < CHANNELS):
  - state[seed_sel] <= fix(seed_data). Load overrides the step for that channel only; other channels step per adv.
  - If fix() substituted a value, lock_err <= 1. It stays set until reset.
  - out_data and out_valid are unaffected that cycle.
- seed_sel >= CHANNELS: load ignored, no flag.
- Reset mid-transfer: sample discarded, out_valid drops immediately (async).
- Pure sequential core: no combinational path from inputs to outputs.

Test Plan:
1. Reset -> out_valid=0, out_data=0, lock_err=0. Then en=1, out_ready=1 -> out_valid=1 after first edge; first word equals OUT_BIT of each reset seed.
2. Default params: load seed 32'h1 into ch0, then run with out_ready=1 -> out_data[7] is 0 on transfers 1-5, 1 on transfer 6, 0 on transfers 7-30.
3. en=1, out_ready=0 for 10 cycles mid-stream -> out_data stable and out_valid=1 throughout. After release, the transfer sequence is identical to an unstalled golden-model run.
4. Load seed 0 (and separately 32'h8000_0000 with TAP_A=30) into ch3 -> ch3 state=1, lock_err rises and stays 1; other channels continue undisturbed.
5. CHANNELS=3 -> out_data 3 bits, seed_sel 2 bits; seed_sel=3 load has no effect and does not set lock_err.
6. Assert rst_n=0 mid-stream with out_valid=1 -> outputs clear immediately. After release, the output sequence restarts identical to the post-reset sequence of scenario 1.
